// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_access load/store unit: FSM states,
// RV32I funct3 width codes, store strobe/data shaping and load extension.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } width_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Any code that is not a byte or half flavour is treated as a full word.
    function automatic width_e width_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return W_BYTE;
            F3_H, F3_HU: return W_HALF;
            default:     return W_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] store_strb(input width_e w, input logic [1:0] lo);
        case (w)
            W_BYTE:  return 4'b0001 << lo;
            W_HALF:  return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input width_e w, input logic [31:0] wd);
        case (w)
            W_BYTE:  return {4{wd[7:0]}};
            W_HALF:  return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // lane holds the selected byte/half in its low bits.
    function automatic logic [31:0] extend(input width_e w, input logic uns, input logic [31:0] lane);
        case (w)
            W_BYTE:  return uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            W_HALF:  return uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: return lane;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus between the load/store unit and memory.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: combinational lane select and sign/zero extension of load data.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);
    width_e      w;
    logic [31:0] lane;

    always_comb begin
        w    = width_of(funct3);
        lane = rdata;
        case (w)
            W_BYTE:  lane = rdata >> {addr_lo, 3'b000};
            W_HALF:  lane = addr_lo[1] ? (rdata >> 16) : rdata;
            default: lane = rdata;
        endcase
        data_out = extend(w, is_unsigned(funct3), lane);
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I load/store unit driving a req/gnt/rvalid data-memory bus with a wait timeout.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned h/w accesses without touching the bus.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_load,
    input  logic         is_store,
    input  logic [2:0]   funct3,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  rdata_out,
    output logic         bus_err,
    output logic         misalign,
    mem_access_if.master dmem
);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic        bus_err_q, bus_err_d;
    logic        trap;
    logic        in_req;
    logic [7:0]  cnt_inc;
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata    (dmem.dmem_rdata),
        .addr_lo  (addr_q[1:0]),
        .funct3   (funct3_q),
        .data_out (load_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        trap = 1'b0;
        if (is_load || is_store) begin
            case (width_of(funct3))
                W_HALF:  trap = addr[0];
                W_WORD:  trap = (addr[1:0] != 2'b00);
                default: trap = 1'b0;
            endcase
        end
        misalign_d = misalign_q;
        if (state_q == S_IDLE && start) misalign_d = trap;
    end

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        store_d   = store_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d    = addr;
                    wdata_d   = wdata_in;
                    funct3_d  = funct3;
                    store_d   = is_store;
                    rdata_d   = '0;
                    bus_err_d = 1'b0;
                    cnt_d     = '0;
                    if (trap)                       state_d = S_DONE;
                    else if (is_load || is_store)   state_d = S_REQ;
                    else                            state_d = S_DONE;
                end
            end
            // A grant or response in the timeout cycle still wins over bus_err.
            S_REQ: begin
                cnt_d = cnt_inc;
                if (dmem.dmem_gnt) begin
                    state_d = store_q ? S_DONE : S_RESP;
                end else if (cnt_inc == WAIT_LIM) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            S_RESP: begin
                cnt_d = cnt_inc;
                if (dmem.dmem_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = load_data;
                end else if (cnt_inc == WAIT_LIM) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            store_q   <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            store_q   <= store_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign in_req    = (state_q == S_REQ);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rdata_out = rdata_q;
    assign bus_err   = bus_err_q;

    assign dmem.dmem_req   = in_req;
    assign dmem.dmem_we    = in_req && store_q;
    assign dmem.dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign dmem.dmem_wstrb = (in_req && store_q) ? store_strb(width_of(funct3_q), addr_q[1:0]) : 4'b0000;
    assign dmem.dmem_wdata = (in_req && store_q) ? store_data(width_of(funct3_q), wdata_q) : '0;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed load/store/timeout/reset cases plus random aligned traffic.
module tb_mem_access;
    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata_in;
    logic        busy, done, bus_err, misalign;
    logic [31:0] rdata_out;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    mem_access_if dif ();

    mem_access #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata_in(wdata_in), .busy(busy), .done(done),
        .rdata_out(rdata_out), .bus_err(bus_err), .misalign(misalign), .dmem(dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          done_cyc;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte offset derived by integer division of the low address bits.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int off_of(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        return (sz == 4) ? 0 : (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int off = off_of(f3, a);
        logic [3:0] s = '0;
        for (int k = 0; k < 4; k++) s[k] = (k >= off) && (k < off + sz);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = size_of(f3);
        logic [31:0] v = d >> (8 * off_of(f3, a));
        if (sz == 1) v = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        else if (sz == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.tag, ".rdata"},    rdata_out,          mon_e.rdata);
                chk({mon_e.tag, ".bus_err"},  {31'd0, bus_err},   {31'd0, mon_e.err});
                chk({mon_e.tag, ".misalign"}, {31'd0, misalign},  {31'd0, mon_e.mis});
                chk({mon_e.tag, ".done_cyc"}, 32'(cyc),           32'(mon_e.done_cyc));
            end
        end
    end

    task automatic do_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r, input logic [31:0] exp_rd,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input bit exp_bus, input bit exp_mis, input bit noisy);
        exp_t e;
        bit   tmo = 1'b0;
        bit   granted = 1'b0, rv_done = 1'b0, got_done = 1'b0;
        int   lat, req_n = 0, resp_n = 0;
        if (!exp_bus) lat = 1;
        else if (st) begin
            tmo = (g < 0) || (g + 1 > WAIT_MAX);
            lat = tmo ? WAIT_MAX + 1 : 2 + g;
        end else begin
            tmo = (g < 0) || (r < 0) || (g + r + 2 > WAIT_MAX);
            lat = tmo ? WAIT_MAX + 1 : 3 + g + r;
        end
        e.rdata = tmo ? 32'h0 : exp_rd;
        e.err   = tmo;
        e.mis   = exp_mis;
        e.tag   = tag;
        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata_in = wd;
        e.done_cyc = cyc + lat;
        sb_q.push_back(e);
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clk);
            if (noisy) begin
                addr = 32'hFFFF_FFFC; wdata_in = 32'h0; funct3 = 3'b000; is_load = 1'b0; is_store = 1'b1;
            end else begin
                start = 1'b0;
            end
            dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = $urandom;
            if (done) begin
                got_done = 1'b1;
                start = 1'b0;
            end else if (dif.dmem_req) begin
                if (!exp_bus) chk({tag, ".unexpected_req"}, 32'd1, 32'd0);
                if (req_n == 0 && exp_bus) begin
                    chk({tag, ".addr"},  dif.dmem_addr,            {a[31:2], 2'b00});
                    chk({tag, ".we"},    {31'd0, dif.dmem_we},     {31'd0, st});
                    chk({tag, ".wstrb"}, {28'd0, dif.dmem_wstrb},  {28'd0, exp_strb});
                    chk({tag, ".wdata"}, dif.dmem_wdata,           exp_wd);
                end
                if (noisy) begin
                    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'hBAD0_BAD0;
                end
                if (g >= 0 && req_n >= g) begin
                    dif.dmem_gnt = 1'b1; granted = 1'b1;
                end
                req_n++;
            end else if (granted && ld && !rv_done) begin
                if (r >= 0 && resp_n >= r) begin
                    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = rd; rv_done = 1'b1;
                end
                resp_n++;
            end
        end
        if (!got_done) chk({tag, ".done_seen"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, ".held_rdata"}, rdata_out,      e.rdata);
        chk({tag, ".idle"},       {31'd0, busy},  32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        bit          st;
        rst = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata_in = '0;
        dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy",     {31'd0, busy},     32'd0);
        chk("rst.done",     {31'd0, done},     32'd0);
        chk("rst.req",      {31'd0, dif.dmem_req}, 32'd0);
        chk("rst.we",       {31'd0, dif.dmem_we},  32'd0);
        chk("rst.wstrb",    {28'd0, dif.dmem_wstrb}, 32'd0);
        chk("rst.rdata",    rdata_out,         32'd0);
        chk("rst.bus_err",  {31'd0, bus_err},  32'd0);
        chk("rst.misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b1;

        //     tag          ld st f3      addr          wdata         rdata         g  r  exp_rd        strb     exp_wdata     bus mis noisy
        do_op("sw",         0, 1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 1, 0, 0);
        do_op("lb",         1, 0, 3'b000, 32'h103,      32'h0,        32'h80FF0000, 0, 0, 32'hFFFFFF80, 4'b0000, 32'h0,        1, 0, 0);
        do_op("lbu",        1, 0, 3'b100, 32'h103,      32'h0,        32'h80FF0000, 0, 0, 32'h00000080, 4'b0000, 32'h0,        1, 0, 0);
        do_op("none",       0, 0, 3'b010, 32'h300,      32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 0);
        do_op("sh",         0, 1, 3'b001, 32'h202,      32'h00001234, 32'h0,        0, 0, 32'h0,        4'b1100, 32'h12341234, 1, 0, 0);
        do_op("sb",         0, 1, 3'b000, 32'h101,      32'h000000A5, 32'h0,        1, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 1, 0, 0);
        do_op("lh_noisy",   1, 0, 3'b001, 32'h102,      32'h0,        32'h80017FFF, 0, 0, 32'hFFFF8001, 4'b0000, 32'h0,        1, 0, 1);
        do_op("lhu",        1, 0, 3'b101, 32'h102,      32'h0,        32'h80017FFF, 0, 0, 32'h00008001, 4'b0000, 32'h0,        1, 0, 0);
        do_op("lh_lo",      1, 0, 3'b001, 32'h100,      32'h0,        32'h80017FFF, 0, 0, 32'h00007FFF, 4'b0000, 32'h0,        1, 0, 0);
        do_op("lw_slow",    1, 0, 3'b010, 32'h104,      32'h0,        32'h12345678, 1, 1, 32'h12345678, 4'b0000, 32'h0,        1, 0, 0);
        do_op("sw_g3",      0, 1, 3'b010, 32'h108,      32'hA5A55A5A, 32'h0,        3, 0, 32'h0,        4'b1111, 32'hA5A55A5A, 1, 0, 0);
        do_op("st_f3_011",  0, 1, 3'b011, 32'h10C,      32'hCAFEF00D, 32'h0,        0, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 1, 0, 0);
        do_op("ld_f3_111",  1, 0, 3'b111, 32'h110,      32'h0,        32'h89ABCDEF, 0, 0, 32'h89ABCDEF, 4'b0000, 32'h0,        1, 0, 0);
        do_op("ld_tmo_gnt", 1, 0, 3'b010, 32'h114,      32'h0,        32'h55,      -1, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0);
        do_op("ld_tmo_rv",  1, 0, 3'b010, 32'h118,      32'h0,        32'h77,       0,-1, 32'h0,        4'b0000, 32'h0,        1, 0, 0);
        do_op("lw_ok",      1, 0, 3'b010, 32'h11C,      32'h0,        32'h0BADF00D, 0, 0, 32'h0BADF00D, 4'b0000, 32'h0,        1, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        do_op("lw_mis",     1, 0, 3'b010, 32'h101,      32'h0,        32'h11223344, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 0);
        do_op("sh_mis",     0, 1, 3'b001, 32'h203,      32'h0000BEEF, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 0);
`else
        do_op("lw_mis",     1, 0, 3'b010, 32'h101,      32'h0,        32'h11223344, 0, 0, 32'h11223344, 4'b0000, 32'h0,        1, 0, 0);
        do_op("sh_mis",     0, 1, 3'b001, 32'h203,      32'h0000BEEF, 32'h0,        0, 0, 32'h0,        4'b1100, 32'hBEEFBEEF, 1, 0, 0);
`endif
        do_op("sw_after",   0, 1, 3'b010, 32'h120,      32'h01020304, 32'h0,        0, 0, 32'h0,        4'b1111, 32'h01020304, 1, 0, 0);

        // Reset while waiting for a load response; the late response must be dropped.
        do_op("pre_rst",    1, 0, 3'b010, 32'h130,      32'h0,        32'hFEEDFACE, 0, 0, 32'hFEEDFACE, 4'b0000, 32'h0,        1, 0, 0);
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h140;
        @(negedge clk);
        start = 1'b0;
        chk("rstmid.req", {31'd0, dif.dmem_req}, 32'd1);
        dif.dmem_gnt = 1'b1;
        @(negedge clk);
        dif.dmem_gnt = 1'b0;
        chk("rstmid.in_resp", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'h5A5A5A5A;
        chk("rstmid.busy",  {31'd0, busy},         32'd0);
        chk("rstmid.req0",  {31'd0, dif.dmem_req}, 32'd0);
        chk("rstmid.rdata", rdata_out,             32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rstmid.no_done", {31'd0, done}, 32'd0);
            chk("rstmid.idle",    {31'd0, busy}, 32'd0);
        end
        dif.dmem_rvalid = 1'b0;

        for (int n = 0; n < 12; n++) begin
            st = 1'($urandom_range(0, 1));
            if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            a  = $urandom & ~(32'(size_of(f3)) - 32'd1);
            wd = $urandom;
            rd = $urandom;
            if (st) do_op($sformatf("rnd%0d_st", n), 0, 1, f3, a, wd, 32'h0, $urandom_range(0, 1), 0,
                          32'h0, m_strb(f3, a), m_wdata(f3, wd), 1, 0, 0);
            else    do_op($sformatf("rnd%0d_ld", n), 1, 0, f3, a, 32'h0, rd, $urandom_range(0, 1), $urandom_range(0, 1),
                          m_load(f3, a, rd), 4'b0000, 32'h0, 1, 0, 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter WAIT_MAX, default 255, SHALL set the bus-wait timeout in cycles (range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-low reset.
REQ-004 start  in  1  SHALL request one memory operation, sampled in IDLE only.
REQ-005 is_load, is_store  in  1 each  SHALL give the operation kind; both 0 means no access.
REQ-006 funct3  in  3  SHALL give the RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 addr  in  32  SHALL be the byte address from the ALU result; wdata_in  in  32  SHALL be the store data (rs2).
REQ-008 busy  out  1  SHALL be high in every state except IDLE.
REQ-009 done  out  1  SHALL be a one-cycle completion pulse; rdata_out  out  32  SHALL be the extended load data.
REQ-010 bus_err  out  1  SHALL flag a timeout; misalign  out  1  SHALL flag a misaligned access (macro only).
REQ-011 dmem_req, dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_wstrb  out  4  SHALL form the request bus.
REQ-012 dmem_gnt, dmem_rvalid  in  1; dmem_rdata  in  32  SHALL form the grant/response bus.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-014 IDLE + start=1: latch addr, wdata_in, funct3, kind; go to REQ if is_load|is_store, else DONE with rdata_out=0.
REQ-015 start while busy SHALL be ignored.
REQ-016 REQ: dmem_req=1 held stable until dmem_gnt=1; store+gnt -> DONE; load+gnt -> RESP.
REQ-017 RESP: dmem_rvalid=1 captures dmem_rdata and goes to DONE; dmem_rvalid outside RESP SHALL be ignored.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; rdata_out/bus_err/misalign held until the next start.
REQ-019 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we=1 only for stores.
REQ-020 Store strobes: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'b1111; dmem_wdata SHALL replicate the byte/half across lanes.
REQ-021 Loads SHALL select the lane by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passes through.
REQ-022 Wait counter SHALL clear on entry to REQ and count each cycle in REQ/RESP; on reaching WAIT_MAX -> DONE with bus_err=1, rdata_out=0.
REQ-023 Minimum latency: store start at T, done at T+2; load done at T+3 when gnt and rvalid arrive immediately.
REQ-024 Unused funct3 codes SHALL behave as w.

Reset
REQ-025 rst=0 SHALL force IDLE, counter 0, and all outputs 0 at the next edge, including mid-operation; in-flight responses SHALL be discarded.

Configuration
REQ-026 With MEM_MISALIGN_TRAP_EN defined, h at addr[0]=1 or w at addr[1:0]!=0 SHALL skip the bus, go to DONE with misalign=1, and leave rdata_out=0.
REQ-027 Without MEM_MISALIGN_TRAP_EN, misalign SHALL be tied 0 and low address bits SHALL only select lanes (h uses addr[1], w ignores addr[1:0]).

Structure
REQ-028 State encoding, funct3 width codes, and the strobe/extend functions SHALL live in shared package mem_pkg.
REQ-029 Load lane select and extension SHALL be sub-module load_align (combinational); the FSM stays in mem_access.

Verification
REQ-030 sw addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_wstrb=1111, dmem_addr=0x100, done at T+2.
REQ-031 lb addr=0x103, rdata=0x80FF_0000, gnt T+1, rvalid T+2 -> rdata_out=0xFFFFFF80, done T+3; lbu same -> 0x00000080.
REQ-032 sh addr=0x202, wdata=0x1234 -> wstrb=1100, dmem_wdata=0x12341234.
REQ-033 Load with gnt held low, WAIT_MAX=4 -> bus_err=1, done pulse, rdata_out=0, then IDLE.
REQ-034 rst=0 in RESP, then late rvalid -> dmem_req=0, busy=0, no done pulse.
REQ-035 MEM_MISALIGN_TRAP_EN, lw addr=0x101 -> no dmem_req, misalign=1, done at T+1.
